ring_ctrl: RTL and testbench
============================

RING_CTRL -- requirements
Module: ring_ctrl

Interface
REQ-001 Parameter ADDR_SIZE, default 4, memory address width; DEPTH = 2**ADDR_SIZE entries.
REQ-002 Parameter BYTE_SIZE, default 8, data word width.
REQ-003 clock  in  1  sole clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  producer offers in_data.
REQ-006 in_ready  out  1  block accepts a word this cycle.
REQ-007 in_data  in  BYTE_SIZE  word to enqueue.
REQ-008 out_valid  out  1  out_data holds the oldest stored word.
REQ-009 out_ready  in  1  consumer takes out_data this cycle.
REQ-010 out_data  out  BYTE_SIZE  oldest stored word.
REQ-011 count  out  ADDR_SIZE+1  number of stored words, 0..DEPTH.
REQ-012 ovf  out  1  sticky flag: push attempted while full.
REQ-013 mem_wen, mem_waddr[ADDR_SIZE], mem_wdata[BYTE_SIZE]  out  write port to the external Mem.
REQ-014 mem_raddr1[ADDR_SIZE] out, mem_rdata1[BYTE_SIZE] in  head read port (combinational read).
REQ-015 mem_raddr2[ADDR_SIZE] out, mem_rdata2[BYTE_SIZE] in  lookahead read port.
REQ-016 peek_valid  out  1, peek_data  out  BYTE_SIZE  second-oldest word.

Function
REQ-017 Block SHALL hold no storage array; storage is the external Mem (1 write, 2 combinational reads).
REQ-018 State: wr_ptr, rd_ptr (ADDR_SIZE bits, wrap DEPTH-1 -> 0), count (ADDR_SIZE+1 bits), ovf.
REQ-019 in_ready = !reset && (count != DEPTH); out_valid = (count != 0); both combinational from state.
REQ-020 push = in_valid && in_ready; pop = out_valid && out_ready.
REQ-021 mem_wen = push, mem_waddr = wr_ptr, mem_wdata = in_data, all combinational same cycle.
REQ-022 mem_raddr1 = rd_ptr; out_data = mem_rdata1.
REQ-023 On push wr_ptr increments mod DEPTH; on pop rd_ptr increments mod DEPTH.
REQ-024 count: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-025 Latency: word pushed in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 when the block was empty; no same-cycle pass-through.
REQ-026 Full: in_ready=0; simultaneous pop does not enable a push in the same cycle.
REQ-027 Empty: out_valid=0 and out_data is don't-care; out_ready ignored.
REQ-028 ovf set when in_valid && count==DEPTH; cleared only by reset.
REQ-029 Same-address read-during-write occurs only when empty; no bypass required.

Reset
REQ-030 While reset=1: wr_ptr, rd_ptr, count, ovf <= 0 at clock edge; in_ready=0, mem_wen=0.
REQ-031 After reset: out_valid=0, count=0, peek_valid=0, in_ready=1 in first cycle with reset=0.
REQ-032 Reset mid-operation SHALL discard all queued words logically; Mem contents are not cleared.

Configuration
REQ-033 Macro RING_CTRL_PEEK_EN defined: mem_raddr2 = rd_ptr+1 mod DEPTH, peek_data = mem_rdata2, peek_valid = (count >= 2).
REQ-034 Macro undefined: mem_raddr2 = rd_ptr, peek_valid = 0, peek_data = 0; ports remain present.

Structure
REQ-035 Package ring_pkg SHALL hold default ADDR_SIZE/BYTE_SIZE constants and the count-width function.
REQ-036 Sub-module ring_ptr (wrapping incrementer with enable and sync reset) SHALL be instantiated twice.

Verification
REQ-037 Reset, ADDR_SIZE=2: push 1,2,3,4 with out_ready=0 -> count=4, in_ready=0, out_data=1.
REQ-038 From full, extra in_valid=1 -> ovf=1, count stays 4; pop 4 -> order 1,2,3,4, then out_valid=0.
REQ-039 Stream 10 words with in_valid=out_ready=1 -> outputs 10 words in order, count<=1, wr_ptr wraps twice.
REQ-040 PEEK_EN, queue holds 5,6 -> out_data=5, peek_data=6, peek_valid=1; one word -> peek_valid=0.
REQ-041 Assert reset with count=3 -> next cycle count=0, out_valid=0, ovf=0; new push 9 -> out_data=9.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg: default geometry for the ring controller and the helper that
// sizes the occupancy counter (it must represent 0..DEPTH inclusive).
package ring_pkg;

    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEF_BYTE_SIZE = 8;

    // Occupancy counter width: one bit wider than the address so that a
    // completely full ring (DEPTH words) is distinguishable from empty.
    function automatic int count_width(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage : ring_pkg

// File: rtl/ring_ptr.sv
// ring_ptr: wrapping pointer for the ring controller. Advances by one when
// enabled and wraps from 2**W-1 back to 0; synchronous active-high reset.
module ring_ptr #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] ptr
);

    // Pointer register: natural W-bit overflow implements the mod-DEPTH wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= {W{1'b0}};
        end else if (en) begin
            ptr <= ptr + W'(1'b1);
        end else begin
            ptr <= ptr;
        end
    end

endmodule : ring_ptr

// File: rtl/ring_ctrl.sv
// ring_ctrl: FIFO control for a ring buffer held in an external memory with
// one write port and two combinational read ports. Handshakes on both sides
// use valid/ready; a sticky ovf flag records pushes attempted while full.
// Optional lookahead (second-oldest word) is enabled by defining the macro
// RING_CTRL_PEEK_EN; without it the peek outputs are tied off.
module ring_ctrl
    import ring_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int BYTE_SIZE = DEF_BYTE_SIZE
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BYTE_SIZE-1:0]              in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BYTE_SIZE-1:0]              out_data,
    output logic [count_width(ADDR_SIZE)-1:0] count,
    output logic                              ovf,
    output logic                              mem_wen,
    output logic [ADDR_SIZE-1:0]              mem_waddr,
    output logic [BYTE_SIZE-1:0]              mem_wdata,
    output logic [ADDR_SIZE-1:0]              mem_raddr1,
    input  logic [BYTE_SIZE-1:0]              mem_rdata1,
    output logic [ADDR_SIZE-1:0]              mem_raddr2,
    input  logic [BYTE_SIZE-1:0]              mem_rdata2,
    output logic                              peek_valid,
    output logic [BYTE_SIZE-1:0]              peek_data
);

    localparam int CW = count_width(ADDR_SIZE);
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_SIZE);

    logic [ADDR_SIZE-1:0] wr_ptr_s;
    logic [ADDR_SIZE-1:0] rd_ptr_s;
    logic [CW-1:0]        count_r;
    logic                 ovf_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;

    // Handshake decode: full blocks pushes even when a pop happens in the
    // same cycle, and an empty ring ignores out_ready.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {CW{1'b0}});
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (!reset && !full_s) begin
            push_s = in_valid;
        end else begin
            push_s = 1'b0;
        end
        if (!empty_s) begin
            pop_s = out_ready;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign in_ready   = !reset && !full_s;
    assign out_valid  = !empty_s;
    assign count      = count_r;
    assign ovf        = ovf_r;

    assign mem_wen    = push_s;
    assign mem_waddr  = wr_ptr_s;
    assign mem_wdata  = in_data;
    assign mem_raddr1 = rd_ptr_s;
    assign out_data   = mem_rdata1;

    ring_ptr #(.W(ADDR_SIZE)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .en    (push_s),
        .ptr   (wr_ptr_s)
    );

    ring_ptr #(.W(ADDR_SIZE)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .en    (pop_s),
        .ptr   (rd_ptr_s)
    );

    // Occupancy counter: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow: any offer while full sets it; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (in_valid && full_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

`ifdef RING_CTRL_PEEK_EN
    assign mem_raddr2 = rd_ptr_s + ADDR_SIZE'(1'b1);
    assign peek_data  = mem_rdata2;
    assign peek_valid = (count_r >= CW'(2));
`else
    // Lookahead port is present but parked on the head address; its read
    // data is folded into a deliberately unused net.
    logic peek_unused_s;
    assign peek_unused_s = ^mem_rdata2;
    assign mem_raddr2    = rd_ptr_s;
    assign peek_data     = {BYTE_SIZE{1'b0}};
    assign peek_valid    = 1'b0;
`endif

endmodule : ring_ctrl

// File: tb/tb_ring_ctrl.sv
// tb_ring_ctrl: directed bench for ring_ctrl with ADDR_SIZE=2, BYTE_SIZE=8.
// Provides a small external memory (1 write, 2 combinational reads).
module tb_ring_ctrl;

    localparam int AW = 2;
    localparam int BW = 8;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [AW:0]   count;
    logic          ovf;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [BW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr1;
    logic [BW-1:0] mem_rdata1;
    logic [AW-1:0] mem_raddr2;
    logic [BW-1:0] mem_rdata2;
    logic          peek_valid;
    logic [BW-1:0] peek_data;

    logic [BW-1:0] mem [4];

    int tests;
    int fails;

    ring_ctrl #(.ADDR_SIZE(AW), .BYTE_SIZE(BW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .ovf        (ovf),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr1 (mem_raddr1),
        .mem_rdata1 (mem_rdata1),
        .mem_raddr2 (mem_raddr2),
        .mem_rdata2 (mem_rdata2),
        .peek_valid (peek_valid),
        .peek_data  (peek_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // External memory: synchronous write, combinational reads.
    always_ff @(posedge clock) begin
        if (mem_wen) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
    assign mem_rdata1 = mem[mem_raddr1];
    assign mem_rdata2 = mem[mem_raddr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 32'd0);
        check("rst_mem_wen", mem_wen, 32'd0);
        tick();
        tick();
        check("rst_in_ready2", in_ready, 32'd0);
        check("rst_mem_wen2", mem_wen, 32'd0);

        // First cycle out of reset
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_count", count, 32'd0);
        check("post_rst_out_valid", out_valid, 32'd0);
        check("post_rst_in_ready", in_ready, 32'd1);
        check("post_rst_peek_valid", peek_valid, 32'd0);
        check("post_rst_ovf", ovf, 32'd0);

        // Fill with 1,2,3,4 while the consumer stalls
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            #1;
            check("fill_wen", mem_wen, 32'd1);
            check("fill_waddr", mem_waddr, 32'(i));
            check("fill_wdata", mem_wdata, 32'(i + 1));
            if (i == 0) begin
                check("no_passthrough", out_valid, 32'd0);
            end
            tick();
            if (i == 0) begin
                check("latency_valid", out_valid, 32'd1);
                check("latency_data", out_data, 32'd1);
            end
        end
        in_valid = 1'b0;
        #1;
        check("full_count", count, 32'd4);
        check("full_in_ready", in_ready, 32'd0);
        check("full_out_data", out_data, 32'd1);

        // Extra offer while full sets ovf, count unchanged
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        check("full_wen", mem_wen, 32'd0);
        tick();
        check("ovf_set", ovf, 32'd1);
        check("ovf_count", count, 32'd4);

        // Full with simultaneous pop: still no push this cycle
        out_ready = 1'b1;
        #1;
        check("full_pop_in_ready", in_ready, 32'd0);
        check("full_pop_wen", mem_wen, 32'd0);
        check("pop_order_1", out_data, 32'd1);
        tick();
        check("full_pop_count", count, 32'd3);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            #1;
            check("pop_order", out_data, 32'(i));
            tick();
        end
        check("drained_valid", out_valid, 32'd0);
        check("drained_count", count, 32'd0);
        tick();
        check("empty_pop_ignored", count, 32'd0);
        check("ovf_sticky", ovf, 32'd1);
        out_ready = 1'b0;

        // Lookahead: queue holds 5,6 at addresses 0,1
        in_valid = 1'b1;
        in_data  = 8'd5;
        tick();
        in_data  = 8'd6;
        tick();
        in_valid = 1'b0;
        #1;
        check("peek_head", out_data, 32'd5);
`ifdef RING_CTRL_PEEK_EN
        check("peek_data", peek_data, 32'd6);
        check("peek_valid2", peek_valid, 32'd1);
        check("peek_raddr2", mem_raddr2, 32'd1);
`else
        check("peek_data_off", peek_data, 32'd0);
        check("peek_valid_off", peek_valid, 32'd0);
        check("peek_raddr2_off", mem_raddr2, 32'd0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("peek_one_head", out_data, 32'd6);
        check("peek_one_valid", peek_valid, 32'd0);
`ifdef RING_CTRL_PEEK_EN
        check("peek_one_raddr2", mem_raddr2, 32'd2);
`else
        check("peek_one_raddr2_off", mem_raddr2, 32'd1);
`endif
        out_ready = 1'b1;
        tick();
        check("peek_drained", out_valid, 32'd0);

        // Stream 10 words (0x10..0x19); pointers start at 2 and wrap
        for (int k = 0; k <= 10; k++) begin
            in_valid  = (k < 10);
            in_data   = 8'(8'h10 + k);
            out_ready = 1'b1;
            #1;
            if (k < 10) begin
                check("stream_waddr", mem_waddr, 32'((2 + k) % 4));
            end
            if (k > 0) begin
                check("stream_data", out_data, 32'(8'h10 + k - 1));
                check("stream_count", count, 32'd1);
            end
            tick();
        end
        check("stream_end_count", count, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset mid-operation with three words queued
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h70 + i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_count", count, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_count", count, 32'd0);
        check("mid_rst_out_valid", out_valid, 32'd0);
        check("mid_rst_ovf", ovf, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'd9;
        tick();
        in_valid = 1'b0;
        #1;
        check("after_rst_data", out_data, 32'd9);
        check("after_rst_valid", out_valid, 32'd1);
        check("after_rst_count", count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ring_ctrl
